// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter_if : fetch / load-store requester and memory bus signal bundle
// Rev 1.0 : initial release
// ============================================================================
interface mem_bus_arbiter_if #(
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          if_err;

  logic          ls_req;
  logic          ls_we;
  logic [1:0]    ls_len;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [31:0]   ls_rdata;
  logic          ls_err;

  logic          bus_req;
  logic          bus_we;
  logic [3:0]    bus_be;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic [31:0]   bus_rdata;
  logic          bus_err;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_req, ls_we, ls_len, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata, bus_err
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output ls_req, ls_we, ls_len, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_ack, bus_rdata, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : single-port memory bus arbiter for RV32I fetch and load/store
// Optional bus-wait timeout enabled by defining MEM_ARB_TIMEOUT_EN.
// Rev 1.0 : initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mem_bus_arbiter_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BUSY_IF = 3'd1;
  localparam logic [2:0] S_BUSY_LS = 3'd2;
  localparam logic [2:0] S_ERR_IF  = 3'd3;
  localparam logic [2:0] S_ERR_LS  = 3'd4;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be at least 1");
  end

  logic [2:0]    r_state;
  logic          r_last_ls;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [3:0]    r_bus_be;
  logic [AW-1:0] r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic          r_if_rvalid;
  logic          r_if_err;
  logic [31:0]   r_if_rdata;
  logic          r_ls_rvalid;
  logic          r_ls_err;
  logic [31:0]   r_ls_rdata;

  logic          w_idle;
  logic          w_busy;
  logic          w_gnt_ls;
  logic          w_gnt_if;
  logic          w_if_mis;
  logic          w_ls_mis;
  logic [3:0]    w_ls_be;
  logic [31:0]   w_ls_wdata;
  logic          w_start;
  logic          w_end;
  logic          w_tmo;

  assign w_idle = (r_state == S_IDLE);
  assign w_busy = (r_state == S_BUSY_IF) || (r_state == S_BUSY_LS);

  // LS wins a tie unless it won the previous grant.
  assign w_gnt_ls = w_idle && bus.ls_req && (!bus.if_req || !r_last_ls);
  assign w_gnt_if = w_idle && bus.if_req && !w_gnt_ls;

  assign w_if_mis = (bus.if_addr[1:0] != 2'b00);

  always_comb begin
    w_ls_be    = 4'b1111;
    w_ls_wdata = bus.ls_wdata;
    w_ls_mis   = 1'b1;
    case (bus.ls_len)
      2'd0: begin
        w_ls_be    = 4'b0001 << bus.ls_addr[1:0];
        w_ls_wdata = {4{bus.ls_wdata[7:0]}};
        w_ls_mis   = 1'b0;
      end
      2'd1: begin
        w_ls_be    = bus.ls_addr[1] ? 4'b1100 : 4'b0011;
        w_ls_wdata = {2{bus.ls_wdata[15:0]}};
        w_ls_mis   = bus.ls_addr[0];
      end
      2'd2: begin
        w_ls_mis   = (bus.ls_addr[1:0] != 2'b00);
      end
      default: begin
        w_ls_mis   = 1'b1;
      end
    endcase
  end

  assign w_start = (w_gnt_ls && !w_ls_mis) || (w_gnt_if && !w_if_mis);
  assign w_end   = w_busy && (bus.bus_ack || w_tmo);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] r_tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_gnt_ls || w_gnt_if) begin
      r_tmo_cnt <= '0;
    end else if (w_busy && !bus.bus_ack) begin
      r_tmo_cnt <= r_tmo_cnt + CW'(1);
    end
  end

  // Fires on the cycle whose increment would reach TIMEOUT; a same-cycle ack wins.
  assign w_tmo = w_busy && !bus.bus_ack && (r_tmo_cnt == CW'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'b0000;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else if (w_start) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= w_gnt_ls && bus.ls_we;
      r_bus_be    <= w_gnt_ls ? w_ls_be : 4'b1111;
      r_bus_addr  <= w_gnt_ls ? {bus.ls_addr[AW-1:2], 2'b00} : {bus.if_addr[AW-1:2], 2'b00};
      r_bus_wdata <= w_gnt_ls ? w_ls_wdata : 32'h0;
    end else if (w_end) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'b0000;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_ls   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_ls) begin
            r_last_ls <= 1'b1;
            if (w_ls_mis) begin
              r_state     <= S_ERR_LS;
              r_ls_rvalid <= 1'b1;
              r_ls_err    <= 1'b1;
              r_ls_rdata  <= '0;
            end else begin
              r_state     <= S_BUSY_LS;
            end
          end else if (w_gnt_if) begin
            r_last_ls <= 1'b0;
            if (w_if_mis) begin
              r_state     <= S_ERR_IF;
              r_if_rvalid <= 1'b1;
              r_if_err    <= 1'b1;
              r_if_rdata  <= '0;
            end else begin
              r_state     <= S_BUSY_IF;
            end
          end
        end
        S_BUSY_IF: begin
          if (bus.bus_ack) begin
            r_state     <= S_IDLE;
            r_if_rvalid <= 1'b1;
            r_if_err    <= bus.bus_err;
            r_if_rdata  <= bus.bus_rdata;
          end else if (w_tmo) begin
            r_state     <= S_IDLE;
            r_if_rvalid <= 1'b1;
            r_if_err    <= 1'b1;
            r_if_rdata  <= '0;
          end
        end
        S_BUSY_LS: begin
          if (bus.bus_ack) begin
            r_state     <= S_IDLE;
            r_ls_rvalid <= 1'b1;
            r_ls_err    <= bus.bus_err;
            r_ls_rdata  <= r_bus_we ? 32'h0 : bus.bus_rdata;
          end else if (w_tmo) begin
            r_state     <= S_IDLE;
            r_ls_rvalid <= 1'b1;
            r_ls_err    <= 1'b1;
            r_ls_rdata  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = w_gnt_if;
  assign bus.ls_gnt    = w_gnt_ls;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_err    = r_if_err;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.ls_err    = r_ls_err;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire
